// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle.
// Ports: clk_i, rst_i (async, low), start_i, kill_i, funct3_i, rs1/rs2 data,
//   rd_addr_i in; busy_o, done_o, result_o, rd_addr_o out (all registered).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_cap;
  logic [4:0]      r_rd_out;

  logic w_accept;
  logic w_last;

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // operand sign decode
  logic w_sgn_a;
  logic w_sgn_b;

  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    unique case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      3'b010:  w_sgn_a = 1'b1;
      default: ;
    endcase
  end

  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_b_zero;

  assign w_neg_a  = w_sgn_a & rs1_data_i[XLEN-1];
  assign w_neg_b  = w_sgn_b & rs2_data_i[XLEN-1];
  assign w_mag_a  = w_neg_a ? -rs1_data_i : rs1_data_i;
  assign w_mag_b  = w_neg_b ? -rs2_data_i : rs2_data_i;
  assign w_b_zero = (rs2_data_i == '0);

  // one iteration: shift-add (r_lo = multiplier) or restoring
  // divide (r_hi = partial remainder, r_lo = dividend/quotient)
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_diff    = w_rem_sh[XLEN-1:0] - r_b;

  always_comb begin
    if (r_op[2]) begin
      w_hi_nxt = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // sign fix-up on the final iteration's values
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_lo_nxt : w_lo_nxt;
  assign w_rem    = r_neg_r ? -w_hi_nxt : w_hi_nxt;

  always_comb begin
    w_final = w_rem;
    unique case (r_op)
      3'b000:                 w_final = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_rd_cap <= '0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= CW'(XLEN);
        r_op     <= funct3_i;
        r_hi     <= '0;
        r_lo     <= funct3_i[2] ? w_mag_a : w_mag_b;
        r_b      <= funct3_i[2] ? w_mag_b : w_mag_a;
        // divide-by-zero quotient stays all ones; the remainder
        // path naturally rebuilds the dividend
        r_neg_q  <= (w_neg_a ^ w_neg_b) & ~w_b_zero;
        r_neg_r  <= w_neg_a;
        r_rd_cap <= rd_addr_i;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - CW'(1);
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
      end
      if (w_last) begin
        r_result <= w_final;
        r_rd_out <= r_rd_cap;
      end
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random checks of muldiv_unit
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .kill_i     (kill_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          p;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // issue one op from a negedge, scramble inputs while it runs
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input bit disturb, input string tag);
    logic [31:0] exp;
    int lat;
    int busy_cnt;
    exp = ref_op(f, a, b);
    check({tag, " idle_before"}, {31'b0, busy_o}, 32'd0);
    start_i    = 1'b1;
    funct3_i   = f;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
    @(negedge clk);
    start_i  = disturb;
    lat      = 1;
    busy_cnt = busy_o ? 1 : 0;
    while (!done_o && lat < 60) begin
      funct3_i   = 3'($urandom);
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      rd_addr_i  = 5'($urandom);
      @(negedge clk);
      lat++;
      if (busy_o) busy_cnt++;
    end
    start_i = 1'b0;
    check({tag, " done"}, {31'b0, done_o}, 32'd1);
    check({tag, " latency"}, lat, 32'd33);
    check({tag, " busy_cycles"}, busy_cnt, 32'd33);
    check({tag, " result"}, result_o, exp);
    check({tag, " rd"}, {27'b0, rd_addr_o}, {27'b0, rd});
    prev_res = exp;
    prev_rd  = rd;
    @(negedge clk);
    check({tag, " done_pulse"}, {31'b0, done_o}, 32'd0);
    check({tag, " busy_after"}, {31'b0, busy_o}, 32'd0);
    check({tag, " result_held"}, result_o, exp);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0;
    sp[1] = 32'h1;
    sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000;
    sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int dcnt;
    rst_i      = 1'b0;
    start_i    = 1'b0;
    kill_i     = 1'b0;
    funct3_i   = 3'd0;
    rs1_data_i = 32'd0;
    rs2_data_i = 32'd0;
    rd_addr_i  = 5'd0;
    prev_res   = 32'd0;
    prev_rd    = 5'd0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'b0, busy_o}, 32'd0);
    check("rst done", {31'b0, done_o}, 32'd0);
    check("rst result", result_o, 32'd0);
    check("rst rd", {27'b0, rd_addr_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0, "mulh");
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd7, 1'b0, "mulhsu");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd8, 1'b0, "mulhu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0, "rem");
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 1'b0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 1'b0, "remu");
    run_op(3'd4, 32'h1234_5678, 32'd0, 5'd13, 1'b0, "div0");
    run_op(3'd7, 32'h1234_5678, 32'd0, 5'd14, 1'b0, "remu0");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd15, 1'b0, "div0_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd16, 1'b0, "rem0_neg");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b0, "rem_ovf");
    run_op(3'd0, 32'd123, 32'd456, 5'd19, 1'b1, "start_ignored");

    // start together with kill in IDLE is not accepted
    start_i = 1'b1;
    kill_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    kill_i  = 1'b0;
    check("kill_idle busy", {31'b0, busy_o}, 32'd0);

    // kill at cycle 10 of a multiply
    start_i    = 1'b1;
    funct3_i   = 3'd0;
    rs1_data_i = 32'd1000;
    rs2_data_i = 32'd3;
    rd_addr_i  = 5'd30;
    @(negedge clk);
    start_i = 1'b0;
    dcnt = 0;
    repeat (9) begin
      if (done_o) dcnt++;
      @(negedge clk);
    end
    check("kill busy_before", {31'b0, busy_o}, 32'd1);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill busy", {31'b0, busy_o}, 32'd0);
    check("kill result", result_o, prev_res);
    check("kill rd", {27'b0, rd_addr_o}, {27'b0, prev_rd});
    repeat (40) begin
      if (done_o) dcnt++;
      @(negedge clk);
    end
    check("kill no_done", dcnt, 32'd0);
    check("kill result_after", result_o, prev_res);

    // async reset at cycle 15 of a divide
    start_i    = 1'b1;
    funct3_i   = 3'd5;
    rs1_data_i = 32'd99999;
    rs2_data_i = 32'd13;
    rd_addr_i  = 5'd21;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("midrst busy", {31'b0, busy_o}, 32'd0);
    check("midrst done", {31'b0, done_o}, 32'd0);
    check("midrst result", result_o, 32'd0);
    check("midrst rd", {27'b0, rd_addr_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    run_op(3'd5, 32'd99999, 32'd13, 5'd21, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), pick(), pick(), 5'($urandom), 1'($urandom),
             $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file: consumes the RS1/RS2 read data and destination register address in EX, computes over a fixed number of cycles while the pipeline stalls on `busy_o`, and returns the 32-bit result with its destination address for the write-back path into the register file.

## Interface
- `XLEN`, 32: operand/result width (only 32 is supported)
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `start_i`  in  1  request; accepted only in IDLE
- `kill_i`  in  1  flush; aborts any operation in progress
- `funct3_i`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_data_i`  in  32  operand A (dividend / multiplicand)
- `rs2_data_i`  in  32  operand B (divisor / multiplier)
- `rd_addr_i`  in  5  destination register
- `busy_o`  out  1  operation in progress; pipeline holds EX
- `done_o`  out  1  one-cycle pulse: result valid
- `result_o`  out  32  result; held until next accepted start
- `rd_addr_o`  out  5  captured destination; held with result

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `start_i`=1 and `kill_i`=0 → latch `funct3_i`, operands, `rd_addr_i`; load 32 into the iteration counter; → CALC. `start_i` in CALC/DONE is ignored.
- CALC: one iteration per cycle; counter decrements; at counter 1 → DONE. `kill_i`=1 → IDLE immediately, with no `done_o`; `result_o`/`rd_addr_o` keep their previous values.
- DONE: `done_o`=1 for exactly one cycle, with `result_o` and `rd_addr_o` valid; → IDLE unconditionally. `kill_i` in DONE does not suppress `done_o`.
- Signed handling: convert signed operands to magnitudes at accept time. MUL/MULH: both signed. MULHSU: A signed, B unsigned. MULHU/DIVU/REMU: unsigned. Run the unsigned core, then apply the sign on the DONE transition.
- Multiply: radix-2 shift-add into a 64-bit product. MUL returns product[31:0]; MULH* return product[63:32]. Product sign = sign(A) XOR sign(B), negated across the full 64 bits.
- Divide: restoring, 1 quotient bit per cycle. Quotient sign = sign(A) XOR sign(B); remainder takes the sign of the dividend.
- Divisor zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend unchanged.
- Overflow (DIV, A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000; REM → 0.
- Special cases keep the same fixed latency.
- The unit never writes the register file itself. The consumer writes `result_o` to `rd_addr_o` on `done_o`, and suppresses the write for x0.

## Timing
- Reset (async, `rst_i`=0): state IDLE; `busy_o`=0, `done_o`=0, `result_o`=0, `rd_addr_o`=0, counter 0, internal registers 0. Takes effect mid-operation with no `done_o`.
- Start accepted at edge N. `busy_o`=1 from after edge N through the DONE cycle inclusive. `done_o`=1 in the cycle after edge N+32. Total latency: 33 cycles.
- `busy_o` is a registered output, and so is `done_o`; neither depends combinationally on inputs.
- Back-to-back: a new start is accepted on the first IDLE cycle after DONE.
- Operands are sampled only at accept; later input changes have no effect.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 → after 33 cycles `done_o` pulse, `result_o`=0xFFFFFFEB, `rd_addr_o`=5; `busy_o` high for 33 cycles.
- MULH / MULHSU / MULHU with A=B=0x80000000 → 0x40000000 / 0xC0000000 / 0x40000000.
- DIV and REM of 0xFFFFFFF9 (−7) by 2 → 0xFFFFFFFD / 0xFFFFFFFF; DIVU of 100 by 7 → 14, REMU → 2.
- Divide by zero, A=0x12345678: DIV → 0xFFFFFFFF, REMU → 0x12345678; overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- `start_i` re-asserted during CALC with different operands → ignored; original result returned at cycle 33. `kill_i` at cycle 10 → IDLE, no `done_o`, `result_o` unchanged.
- `rst_i` pulled low at cycle 15 mid-divide → immediately IDLE with all outputs 0; a fresh start after release completes normally.
